// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MDU_EARLY_OUT_EN: zero-operand multiplies and divisor>dividend divides finish in one cycle.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic                s1_q, s2_q;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opb;

    // Launch-time decode of the incoming operands
    logic            is_div, sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            short_hit;
    logic [XLEN-1:0] short_res;

    always_comb begin
        is_div    = op[2];
        sgn1      = (op == 3'b001) || (op == 3'b010) || (is_div && !op[0]);
        sgn2      = (op == 3'b001) || (is_div && !op[0]);
        neg1      = sgn1 && src1[XLEN-1];
        neg2      = sgn2 && src2[XLEN-1];
        mag1      = neg1 ? -src1 : src1;
        mag2      = neg2 ? -src2 : src2;
        short_hit = 1'b0;
        short_res = '0;
        if (is_div && (src2 == '0)) begin
            short_hit = 1'b1;
            short_res = op[1] ? src1 : '1;
        end else if (is_div && !op[0] && (src1 == MIN_INT) && (src2 == '1)) begin
            short_hit = 1'b1;
            short_res = op[1] ? '0 : MIN_INT;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!is_div && ((src1 == '0) || (src2 == '0))) begin
            short_hit = 1'b1;
            short_res = '0;
        end else if (is_div && (mag2 > mag1)) begin
            short_hit = 1'b1;
            short_res = op[1] ? src1 : '0;
        end
`endif
    end

    // One iteration step; acc holds {hi, lo} for multiply and {rem, quo} for divide
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [XLEN-1:0]   quo, rmd, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opb};
        rem_ge   = rem_sh >= {1'b0, opb};
        if (!op_q[2])
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        else if (rem_ge)
            acc_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nxt = {acc[2*XLEN-2:0], 1'b0};

        prod = (s1_q ^ s2_q) ? -acc_nxt : acc_nxt;
        quo  = (s1_q ^ s2_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rmd  = s1_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        if (op_q[2])
            final_res = op_q[1] ? rmd : quo;
        else
            final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !flush) state_nxt = short_hit ? DONE : CALC;
            CALC: if (flush) state_nxt = IDLE;
                  else if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            acc    <= '0;
            opb    <= '0;
            result <= '0;
        end else if (state == IDLE && start && !flush) begin
            cnt  <= CNT_W'(XLEN);
            op_q <= op;
            s1_q <= neg1;
            s2_q <= neg2;
            // Divide iterates over the dividend; multiply shifts the multiplier out of lo
            acc  <= is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            opb  <= is_div ? mag2 : mag1;
            if (short_hit) result <= short_res;
        end else if (state == CALC && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) result <= final_res;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule
